// File: rtl/fetch_unit_pkg.sv
// Shared widths, halt encoding and state type for the instruction-fetch stage.
package fetch_unit_pkg;

    localparam int IP_WIDTH   = 8;
    localparam int LINE_WIDTH = 32;

    localparam logic [LINE_WIDTH-1:0] HALT_WORD_DFLT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Line-memory, decode handshake and redirect signals of the fetch stage.
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int IP_W   = IP_WIDTH,
    parameter int LINE_W = LINE_WIDTH
) ();

    logic              start;
    logic              mem_en;
    logic [IP_W-1:0]   mem_ip;
    logic [LINE_W-1:0] mem_line;
    logic [LINE_W-1:0] instr_out;
    logic [IP_W-1:0]   instr_ip;
    logic              instr_valid;
    logic              instr_ready;
    logic              redir_valid;
    logic [IP_W-1:0]   redir_ip;
    logic              halted;

    modport master (
        input  start, mem_line, instr_ready, redir_valid, redir_ip,
        output mem_en, mem_ip, instr_out, instr_ip, instr_valid, halted
    );

    modport slave (
        output start, mem_line, instr_ready, redir_valid, redir_ip,
        input  mem_en, mem_ip, instr_out, instr_ip, instr_valid, halted
    );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the ip, reads line memory, buffers one instruction
// for decode, and handles redirects and the halt word.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                IP_W      = IP_WIDTH,
    parameter int                LINE_W    = LINE_WIDTH,
    parameter logic [IP_W-1:0]   RESET_IP  = '0,
    parameter logic [LINE_W-1:0] HALT_WORD = HALT_WORD_DFLT
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);

    fetch_state_t      r_state;
    logic [IP_W-1:0]   r_ip;
    logic [IP_W-1:0]   r_instr_ip;
    logic [LINE_W-1:0] r_instr_out;
    logic              r_valid;

    logic w_slot_free;
    logic w_halt_hit;

    assign w_slot_free = !r_valid || bus.instr_ready;
    assign w_halt_hit  = (bus.mem_line == HALT_WORD);

    // NOTE: every register here updates with <= so all branches see the
    // pre-edge values of r_state/r_valid/r_ip regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ip        <= RESET_IP;
            r_valid     <= 1'b0;
            r_instr_out <= '0;
            r_instr_ip  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= RUN;
                    end
                end

                RUN, HALT: begin
                    if (bus.redir_valid) begin
                        // Flush wins over a same-cycle transfer; that word is still consumed.
                        r_ip    <= bus.redir_ip;
                        r_valid <= 1'b0;
                        r_state <= RUN;
                    end else if (r_state == RUN && w_slot_free) begin
                        if (w_halt_hit) begin
                            r_state <= HALT;
                            r_valid <= 1'b0;
                        end else begin
                            r_instr_out <= bus.mem_line;
                            r_instr_ip  <= r_ip;
                            r_valid     <= 1'b1;
                            r_ip        <= r_ip + IP_W'(1);
                        end
                    end else if (bus.instr_ready) begin
                        r_valid <= 1'b0;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.mem_en      = (r_state == RUN);
    assign bus.mem_ip      = r_ip;
    assign bus.instr_out   = r_instr_out;
    assign bus.instr_ip    = r_instr_ip;
    assign bus.instr_valid = r_valid;
    assign bus.halted      = (r_state == HALT) && !r_valid;

endmodule
